// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NUM_REQ byte requesters (round-robin by default).
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority where the lowest index wins.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_3125,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_parity,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 uart_tx_start,
    output logic [7:0]           uart_data,
    output logic                 uart_parity_type,
    input  logic                 uart_tx_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GUARD
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   win_idx;
    logic [CNT_W-1:0]   tmo_cnt;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Descending scan: the last hit, i.e. the lowest requesting index, wins.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0]   rr_ptr;

    // Scan offsets NUM_REQ..1 from the last winner; offset 1 is assigned last and so has top priority.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            int cand;
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (req[cand]) win_idx = IDX_W'(cand);
        end
    end
`endif

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            state            <= S_IDLE;
            owner            <= '0;
            tmo_cnt          <= '0;
            grant            <= '0;
            done             <= '0;
            busy             <= 1'b0;
            timeout_err      <= 1'b0;
            uart_tx_start    <= 1'b0;
            uart_data        <= '0;
            uart_parity_type <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            rr_ptr           <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle; a later non-blocking write in the case wins.
            grant         <= '0;
            done          <= '0;
            uart_tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        owner            <= win_idx;
                        uart_data        <= req_data[{win_idx, 3'b000} +: 8];
                        uart_parity_type <= req_parity[win_idx];
                        grant[win_idx]   <= 1'b1;
                        uart_tx_start    <= 1'b1;
                        busy             <= 1'b1;
                        state            <= S_START;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                        rr_ptr           <= win_idx;
`endif
                    end
                end
                S_START: state <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    // A done arriving on the threshold cycle still counts as a normal completion.
                    if (uart_tx_done) begin
                        done[owner] <= 1'b1;
                        state       <= S_GUARD;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_GUARD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_GUARD: begin
                    tmo_cnt <= '0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx model and serial-line receiver.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk_3125 = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_parity = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic           timeout_err;
    logic           uart_tx_start;
    logic [7:0]     uart_data;
    logic           uart_parity_type;
    logic           uart_tx_done;

    logic man_done   = 1'b0;
    logic model_done = 1'b0;
    logic model_en   = 1'b0;
    logic serial     = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx_byte_q[$];
    logic       rx_par_q[$];
    logic       rx_stop_q[$];

    assign uart_tx_done = man_done | model_done;

    always #5 clk_3125 = ~clk_3125;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(255)) dut (
        .clk_3125         (clk_3125),
        .rst              (rst),
        .req              (req),
        .req_data         (req_data),
        .req_parity       (req_parity),
        .grant            (grant),
        .done             (done),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .uart_tx_start    (uart_tx_start),
        .uart_data        (uart_data),
        .uart_parity_type (uart_parity_type),
        .uart_tx_done     (uart_tx_done)
    );

    // Behavioural uart_tx: 11 bits (start, 8 data LSB first, parity, stop), 14 clocks each.
    // parity_type 0 = even, 1 = odd.
    initial begin
        logic [10:0] frame;
        forever begin
            @(posedge clk_3125);
            #1;
            if (model_en && uart_tx_start) begin
                frame = {1'b1, (^uart_data) ^ uart_parity_type, uart_data, 1'b0};
                for (int b = 0; b < 11; b++) begin
                    serial = frame[b];
                    repeat (14) @(posedge clk_3125);
                    #1;
                end
                serial     = 1'b1;
                model_done = 1'b1;
                @(posedge clk_3125);
                #1;
                model_done = 1'b0;
            end
        end
    end

    // Serial receiver: samples the middle of each bit after seeing the start bit.
    initial begin
        logic [9:0] bits;
        forever begin
            @(posedge clk_3125);
            if (model_en && serial == 1'b0) begin
                repeat (7) @(posedge clk_3125);
                for (int i = 0; i < 10; i++) begin
                    repeat (14) @(posedge clk_3125);
                    bits[i] = serial;
                end
                rx_byte_q.push_back(bits[7:0]);
                rx_par_q.push_back(bits[8]);
                rx_stop_q.push_back(bits[9]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_3125);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        req        = '0;
        req_data   = '0;
        req_parity = '0;
        man_done   = 1'b0;
        model_en   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Bounded wait for a grant; an expired bound counts as a failed comparison.
    task automatic wait_grant(input string name);
        for (int t = 0; t < 16 && grant == '0; t++) tick();
        vectors++;
        if (grant === '0) begin
            miscompares++;
            $display("FAIL %s_grant_wait: no grant within 16 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({grant, done, busy, timeout_err, uart_tx_start, uart_data, uart_parity_type} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got grant=%b done=%b busy=%b terr=%b start=%b data=%h par=%b, expected all 0",
                     grant, done, busy, timeout_err, uart_tx_start, uart_data, uart_parity_type);
        end
        rst      = 1'b0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        vectors++;
        if ({done, busy, uart_tx_start} !== '0) begin
            miscompares++;
            $display("FAIL idle_done_ignored: got done=%b busy=%b start=%b, expected 0", done, busy, uart_tx_start);
        end
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        req_data[15:8] = 8'hA5;
        req_parity[1]  = 1'b1;
        req            = 4'b0010;
        tick();
        vectors++;
        if ({grant, uart_tx_start, busy} !== {4'b0010, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL single_grant: got grant=%b start=%b busy=%b, expected 0010 1 1", grant, uart_tx_start, busy);
        end
        req = '0;
        tick();
        vectors++;
        if ({grant, uart_tx_start} !== 5'b0) begin
            miscompares++;
            $display("FAIL single_pulse_width: got grant=%b start=%b, expected 0000 0", grant, uart_tx_start);
        end
        repeat (5) tick();
        vectors++;
        if ({uart_data, uart_parity_type, busy, done} !== {8'hA5, 1'b1, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL single_hold: got data=%h par=%b busy=%b done=%b, expected a5 1 1 0000",
                     uart_data, uart_parity_type, busy, done);
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        vectors++;
        if ({done, busy} !== {4'b0010, 1'b1}) begin
            miscompares++;
            $display("FAIL single_done: got done=%b busy=%b, expected 0010 1", done, busy);
        end
        tick();
        vectors++;
        if ({done, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL single_idle: got done=%b busy=%b, expected 0000 0", done, busy);
        end
        tick();
        vectors++;
        if (uart_tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_no_restart: got start=%b, expected 0", uart_tx_start);
        end
    endtask

    task automatic test_round_robin();
        int         exp_idx;
        logic [N-1:0] exp_g;
        logic [7:0]   exp_d;
        apply_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b1111;
        for (int f = 0; f < 5; f++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = f % N;
`endif
            exp_g          = '0;
            exp_g[exp_idx] = 1'b1;
            exp_d          = 8'(8'h11 * (exp_idx + 1));
            wait_grant("rr");
            vectors++;
            if ({grant, uart_data} !== {exp_g, exp_d}) begin
                miscompares++;
                $display("FAIL rr_frame%0d: got grant=%b data=%h, expected %b %h", f, grant, uart_data, exp_g, exp_d);
            end
            tick();
            tick();
            man_done = 1'b1;
            tick();
            man_done = 1'b0;
            vectors++;
            if (done !== exp_g) begin
                miscompares++;
                $display("FAIL rr_done%0d: got done=%b, expected %b", f, done, exp_g);
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_withdraw();
        logic seen_g2    = 1'b0;
        logic seen_start = 1'b0;
        apply_reset();
        req = 4'b0001;
        wait_grant("withdraw");
        req = '0;
        tick();
        req = 4'b0100;
        tick();
        req = '0;
        seen_g2 = grant[2];
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        for (int t = 0; t < 6; t++) begin
            seen_g2    = seen_g2 | grant[2];
            seen_start = seen_start | uart_tx_start;
            tick();
        end
        vectors++;
        if ({seen_g2, seen_start, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL withdraw: got grant2_seen=%b start_seen=%b busy=%b, expected 0 0 0", seen_g2, seen_start, busy);
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] done_acc = '0;
        apply_reset();
        req = 4'b0001;
        wait_grant("timeout");
        req = '0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            done_acc = done_acc | done;
        end
        vectors++;
        if ({timeout_err, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_early: got terr=%b busy=%b at wait cycle 255, expected 0 1", timeout_err, busy);
        end
        tick();
        done_acc = done_acc | done;
        vectors++;
        if ({timeout_err, busy, done_acc} !== {1'b1, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL timeout_set: got terr=%b busy=%b done_seen=%b, expected 1 1 0000", timeout_err, busy, done_acc);
        end
        tick();
        vectors++;
        if ({timeout_err, busy, done} !== {1'b1, 1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL timeout_idle: got terr=%b busy=%b done=%b, expected 1 0 0000", timeout_err, busy, done);
        end
        req = 4'b0010;
        tick();
        req = '0;
        vectors++;
        if ({grant, timeout_err} !== {4'b0010, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_recover: got grant=%b terr=%b, expected 0010 1", grant, timeout_err);
        end
        tick();
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        vectors++;
        if (done !== 4'b0010) begin
            miscompares++;
            $display("FAIL timeout_recover_done: got done=%b, expected 0010", done);
        end
        tick();
    endtask

    task automatic test_done_at_threshold();
        apply_reset();
        req = 4'b0100;
        wait_grant("thresh");
        req = '0;
        repeat (255) tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        vectors++;
        if ({done, timeout_err} !== {4'b0100, 1'b0}) begin
            miscompares++;
            $display("FAIL thresh_done: got done=%b terr=%b, expected 0100 0", done, timeout_err);
        end
        tick();
        vectors++;
        if ({busy, timeout_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL thresh_idle: got busy=%b terr=%b, expected 0 0", busy, timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        int           dones     = 0;
        int           starts    = 0;
        int           done_cyc  = -1;
        int           start2_cyc = -1;
        logic [N-1:0] done_seq[2];
        apply_reset();
        rx_byte_q.delete();
        rx_par_q.delete();
        rx_stop_q.delete();
        done_seq[0]     = '0;
        done_seq[1]     = '0;
        model_en        = 1'b1;
        req_data[7:0]   = 8'h55;
        req_data[31:24] = 8'h0F;
        req_parity      = 4'b1000;
        req             = 4'b1001;
        for (int cyc = 1; cyc <= 1000 && dones < 2; cyc++) begin
            tick();
            if (grant[0]) req[0] = 1'b0;
            if (grant[3]) req[3] = 1'b0;
            if (uart_tx_start) begin
                starts++;
                if (starts == 2) start2_cyc = cyc;
            end
            if (model_done && done_cyc < 0) done_cyc = cyc;
            if (done != '0) begin
                done_seq[dones] = done;
                dones++;
            end
        end
        vectors++;
        if ({dones, done_seq[0], done_seq[1]} !== {32'd2, 4'b0001, 4'b1000}) begin
            miscompares++;
            $display("FAIL b2b_done_order: got count=%0d %b %b, expected 2 0001 1000", dones, done_seq[0], done_seq[1]);
        end
        vectors++;
        if ((done_cyc > 0 && start2_cyc - done_cyc >= 2) !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_gap: got first done at %0d second start at %0d, expected gap >= 2", done_cyc, start2_cyc);
        end
        vectors++;
        if (rx_byte_q.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_frames: got %0d frames on the line, expected 2", rx_byte_q.size());
        end else begin
            vectors++;
            if ({rx_byte_q[0], rx_par_q[0], rx_stop_q[0]} !== {8'h55, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL b2b_frame0: got data=%h par=%b stop=%b, expected 55 0 1", rx_byte_q[0], rx_par_q[0], rx_stop_q[0]);
            end
            vectors++;
            if ({rx_byte_q[1], rx_par_q[1], rx_stop_q[1]} !== {8'h0F, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL b2b_frame1: got data=%h par=%b stop=%b, expected 0f 1 1", rx_byte_q[1], rx_par_q[1], rx_stop_q[1]);
            end
        end
        tick();
        tick();
        model_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        req_data[23:16] = 8'hC3;
        req_parity[2]   = 1'b1;
        req             = 4'b0100;
        wait_grant("midrst");
        req = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({grant, done, busy, timeout_err, uart_tx_start, uart_data, uart_parity_type} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got grant=%b done=%b busy=%b terr=%b start=%b data=%h par=%b, expected all 0",
                     grant, done, busy, timeout_err, uart_tx_start, uart_data, uart_parity_type);
        end
        rst = 1'b0;
        req = 4'b1111;
        tick();
        req = '0;
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_pointer: got grant=%b, expected 0001", grant);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_timeout();
        test_done_at_threshold();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
